// File: rtl/queue_param.sv
// Parametrised circular-buffer FIFO with ready/valid on both sides, optional pipe and flow modes.
// Define QUEUE_PARAM_COUNT_EN to expose the io_count occupancy port.
module queue_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PIPE  = 0,
  parameter int unsigned FLOW  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_enq_valid,
  output logic                       io_enq_ready,
  input  logic [WIDTH-1:0]           io_enq_bits,
  output logic                       io_deq_valid,
  input  logic                       io_deq_ready,
  output logic [WIDTH-1:0]           io_deq_bits
`ifdef QUEUE_PARAM_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] io_count
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    enq_ptr;
  logic [PW-1:0]    deq_ptr;
  logic             maybe_full;
  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             do_enq;
  logic             do_deq;
  logic             bypass;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] mem [DEPTH];

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status and handshake.
  always_comb begin
    ptr_match    = (enq_ptr == deq_ptr);
    empty        = ptr_match & ~maybe_full;
    full         = ptr_match & maybe_full;
    io_enq_ready = ~full | ((PIPE != 0) & io_deq_ready);
    io_deq_valid = ~empty | ((FLOW != 0) & io_enq_valid);
    do_enq       = io_enq_valid & io_enq_ready;
    do_deq       = io_deq_valid & io_deq_ready;
    bypass       = (FLOW != 0) & empty;
    // A bypassed item never touches storage or pointers.
    wr_en        = do_enq & ~(bypass & do_deq);
    rd_en        = do_deq & ~bypass;
    io_deq_bits  = bypass ? io_enq_bits : mem[deq_ptr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (wr_en) enq_ptr <= ptr_next(enq_ptr);
      if (rd_en) deq_ptr <= ptr_next(deq_ptr);
      if (wr_en != rd_en) maybe_full <= wr_en;
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[enq_ptr] <= io_enq_bits;
  end

`ifdef QUEUE_PARAM_COUNT_EN
  localparam int unsigned CW = $clog2(DEPTH + 1);

  always_comb begin
    io_count = CW'(enq_ptr) - CW'(deq_ptr);
    if (enq_ptr < deq_ptr) io_count = io_count + CW'(DEPTH);
    if (full) io_count = CW'(DEPTH);
  end
`endif

endmodule
